// File: rtl/fp_mul_scheduler_pkg.sv
// Shared types and constants for the floating-point multiply scheduler.
// Field positions refer to IEEE-754 single-precision operands.
package fp_mul_scheduler_pkg;

    localparam int DATA_W          = 32;
    localparam int NREQ            = 2;
    localparam int EXP_MSB         = 30;
    localparam int EXP_LSB         = 23;
    localparam int SIGN_BIT        = 31;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Zero and denormal operands both have an all-zero exponent field.
    function automatic logic exp_is_zero(input logic [DATA_W-1:0] x);
        return (x[EXP_MSB:EXP_LSB] == '0);
    endfunction

    function automatic logic [DATA_W-1:0] signed_zero(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        return {a[SIGN_BIT] ^ b[SIGN_BIT], {(DATA_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fp_mul_scheduler_arb.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arbiter2
    import fp_mul_scheduler_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one sequential FP multiplier between two requesters with round-robin
// arbitration, a zero/denormal bypass and a completion watchdog.
module fp_mul_scheduler
    import fp_mul_scheduler_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [NREQ-1:0]   req_ready,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic              busy
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

    state_t            state, state_nxt;
    logic              last;
    logic              id;
    logic [DATA_W-1:0] op_a, op_b, res;
    logic              err;
    logic [WD_W-1:0]   wd, wd_inc;
    logic [NREQ-1:0]   grant;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              accept, timeout, zero_op;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .last  (last),
        .grant (grant)
    );

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel_a     = grant[1] ? req_a1 : req_a0;
    assign sel_b     = grant[1] ? req_b1 : req_b0;
    assign zero_op   = exp_is_zero(sel_a) || exp_is_zero(sel_b);

    // Abort once the post-increment count would reach TIMEOUT-1, so the
    // response lands exactly TIMEOUT cycles after the start pulse.
    assign wd_inc  = wd + 1'b1;
    assign timeout = (wd_inc == WD_W'(TIMEOUT - 1));

    assign mul_start = (state == ISSUE);
    assign mul_a     = op_a;
    assign mul_b     = op_b;
    assign rsp_valid = (state == RESP) ? {id, ~id} : '0;
    assign rsp_data  = res;
    assign rsp_err   = err;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_op ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mul_done || timeout) state_nxt = RESP;
            RESP:    if (rsp_ready[id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
            id   <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            err  <= 1'b0;
            wd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        id   <= grant[1];
                        res  <= signed_zero(sel_a, sel_b);
                        err  <= 1'b0;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd_inc;
                    if (mul_done) begin
                        res <= mul_result;
                    end else if (timeout) begin
                        res <= '0;
                        err <= 1'b1;
                    end
                end
                RESP: if (rsp_ready[id]) last <= id;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_mul_scheduler.md
# fp_mul_scheduler

Shares one sequential floating-point multiply unit between two requesters. Each requester offers a pair of 32-bit single-precision operands over a valid/ready channel. The block arbitrates round-robin, issues the winning pair to the shared unit, waits for its completion pulse, and returns the result to the granted requester on a valid/ready response channel. It also short-circuits zero/denormal operands, guards the unit with a watchdog, and sits directly between the requester-side wrappers and the shift-add multiplier top.

## Interface
- `TIMEOUT`, 64 — cycles spent waiting for `mul_done` before the request is aborted with an error.
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  2  — per-requester operand-pair valid; bit i belongs to requester i.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  32 each  — operands per requester (IEEE-754 single).
- `req_ready`  out  2  — per-requester accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `mul_start`  out  1  — one-cycle pulse that launches the shared unit.
- `mul_a`, `mul_b`  out  32 each  — operands to the unit; held stable from `mul_start` until completion or abort.
- `mul_done`  in  1  — one-cycle completion pulse from the unit.
- `mul_result`  in  32  — unit result; valid in the `mul_done` cycle.
- `rsp_valid`  out  2  — per-requester response valid.
- `rsp_data`  out  32  — result, shared by both response channels.
- `rsp_err`  out  1  — response is a watchdog abort.
- `rsp_ready`  in  2  — per-requester response accept.
- `busy`  out  1  — high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready` is asserted only for the arbiter winner, and only when that requester's `req_valid` is high.
    - On accept, latch the operands, the requester id and the zero flag.
    - Go to RESP if either operand's exponent field `[30:23]` is 0; otherwise go to ISSUE.
  - ISSUE: drive `mul_start` = 1 for exactly one cycle, clear the watchdog counter, go to WAIT.
  - WAIT: increment the watchdog each cycle.
    - On `mul_done`, latch `mul_result` and go to RESP with `rsp_err` = 0.
    - If the counter reaches `TIMEOUT-1` without `mul_done`, go to RESP with data 0 and `rsp_err` = 1.
    - If `mul_done` and the timeout occur in the same cycle, `mul_done` wins.
  - RESP: hold `rsp_valid[id]` and the data stable until `rsp_ready[id]`, then go to IDLE. The pointer update happens on this exit (see Arbitration).
- Zero path: the result is the signed zero `{a[31]^b[31], 31'b0}` and the unit is never started.
- Arbitration (round-robin):
  - `last` = id of the requester last served.
  - If both requesters are valid, grant `~last`; if only one is valid, grant it.
  - `last` updates when RESP exits.
  - `last` resets to 1, so requester 0 wins the first contention.
- Ignored inputs: `mul_done` outside WAIT; `rsp_ready` of the non-granted requester.
- Operand changes on `req_*` after the accept do not affect the request in flight.

## Timing
- Reset values: `req_ready` = 0, `mul_start` = 0, `mul_a`/`mul_b` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `busy` = 0, state = IDLE, `last` = 1, watchdog = 0.
- Accept in cycle T:
  - `mul_start` is high in cycle T+1.
  - `mul_done` in cycle T+1+N gives `rsp_valid` in T+2+N.
  - Zero path: `rsp_valid` in T+1.
- The earliest next accept is the cycle after the `rsp_valid`/`rsp_ready` handshake; there is no overlap and at most one request is in flight.
- Abort: `rsp_valid` is high `TIMEOUT` cycles after `mul_start`.
- Reset asserted in any state returns everything to its reset values on the next edge, drops any pending response, and issues no `mul_start`.
- `req_ready` and `rsp_valid` never depend combinationally on `rsp_ready`. `req_ready` depends combinationally on `req_valid` through the arbiter.

## Structure
- Shared package contents:
  - state enum: IDLE, ISSUE, WAIT, RESP;
  - `EXP_MSB` = 30, `EXP_LSB` = 23, `SIGN_BIT` = 31;
  - `NREQ` = 2;
  - default `TIMEOUT`.
- Sub-module `rr_arbiter2`: inputs `req[1:0]`, `last`; output one-hot `grant[1:0]`; purely combinational.
- The FSM, operand/result registers and watchdog stay in `fp_mul_scheduler`.

## Test plan
- Single request, the model answers `mul_done` 26 cycles after `mul_start`: requester 0 sends 0x40000000 × 0x40400000 → exactly one `mul_start` pulse; requester 0 receives `rsp_data` 0x40C00000 with `rsp_err` 0.
- Simultaneous requests after reset, both held valid: requester 0 served first, then requester 1; with both held continuously valid, the grants alternate 0,1,0,1.
- Zero bypass: 0x00000000 × 0xC0400000 → `rsp_data` 0x80000000 one cycle after accept; `mul_start` never asserted.
- Watchdog, `TIMEOUT` = 8, model never pulses `mul_done` → `rsp_err` 1, `rsp_data` 0, `rsp_valid` 8 cycles after `mul_start`; a later `mul_done` in IDLE is ignored.
- Backpressure: `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_data` stable; no `req_ready` issued until the handshake completes.
- `rst` pulsed mid-WAIT → all outputs reach their reset values on the next edge; the next request is served normally, with requester 0 winning contention.
